// File: rtl/zc_track_ctrl_if.sv
// Stream bundle between the zero-crossing track controller and its
// surroundings: the I and Q detector crossing-count streams in, and the
// merged, source-tagged crossing stream out.
//
//   i_zc_tdata/tvalid/tready : I detector crossing count stream
//   q_zc_tdata/tvalid/tready : Q detector crossing count stream
//   o_tdata/tuser/tvalid     : merged crossing count, tuser 0 = I, 1 = Q
//   o_tready                 : downstream ready for the merged stream
//
// master : the controller (drives the detector treadys and the merged stream)
// slave  : the detectors plus downstream consumer
interface zc_track_ctrl_if #(
    parameter int unsigned COUNTER_SIZE = 32
);
    logic [COUNTER_SIZE-1:0] i_zc_tdata;
    logic                    i_zc_tvalid;
    logic                    i_zc_tready;
    logic [COUNTER_SIZE-1:0] q_zc_tdata;
    logic                    q_zc_tvalid;
    logic                    q_zc_tready;
    logic [COUNTER_SIZE-1:0] o_tdata;
    logic                    o_tuser;
    logic                    o_tvalid;
    logic                    o_tready;

    modport master (
        input  i_zc_tdata, i_zc_tvalid, q_zc_tdata, q_zc_tvalid, o_tready,
        output i_zc_tready, q_zc_tready, o_tdata, o_tuser, o_tvalid
    );

    modport slave (
        output i_zc_tdata, i_zc_tvalid, q_zc_tdata, q_zc_tvalid, o_tready,
        input  i_zc_tready, q_zc_tready, o_tdata, o_tuser, o_tvalid
    );
endinterface

// File: rtl/zc_track_ctrl.sv
// Sequencing and arbitration controller for the I/Q zero-crossing detector
// pair of the doppler tracker. On start it clears both detectors, fires their
// offset calibration and waits out the calibration window (2^log_cal_len
// input samples). It then round-robin merges the two crossing-count streams
// into one tagged stream. A watchdog restarts the clear/calibrate sequence
// when no crossing has been accepted for `timeout` input samples.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear            : synchronous soft clear back to IDLE
//   start            : pulse that begins clear/calibrate/track
//   log_cal_len      : log2 calibration length in samples (0 = none)
//   timeout          : watchdog limit in samples (0 = disabled)
//   s_tvalid         : sample strobe of the stream feeding the detectors
//   det_clear        : one-cycle clear pulse to both detectors
//   init_cal_i/q     : one-cycle calibration start pulses
//   zc               : detector input streams and merged output stream
//   tracking         : high while tracking
//   recal_count      : saturating count of watchdog recalibrations
module zc_track_ctrl #(
    parameter int unsigned COUNTER_SIZE = 32,
    parameter int unsigned RECAL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start,
    input  logic [31:0]            log_cal_len,
    input  logic [31:0]            timeout,
    input  logic                   s_tvalid,
    output logic                   det_clear,
    output logic                   init_cal_i,
    output logic                   init_cal_q,
    zc_track_ctrl_if.master        zc,
    output logic                   tracking,
    output logic [RECAL_CNT_W-1:0] recal_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CAL_START,
        S_CAL_WAIT,
        S_TRACK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [47:0] cal_cnt;
    logic [47:0] cal_load;
    logic [5:0]  cal_sh;
    logic [31:0] wd_cnt;
    logic [32:0] wd_inc;
    logic        last_grant_q;
    logic        slot_free;
    logic        grant_i;
    logic        grant_q;
    logic        wd_fire;
    logic        enter_clr;

    always_comb begin
        state_nxt      = state;
        det_clear      = 1'b0;
        init_cal_i     = 1'b0;
        init_cal_q     = 1'b0;
        tracking       = 1'b0;
        grant_i        = 1'b0;
        grant_q        = 1'b0;
        wd_fire        = 1'b0;
        // Outside tracking the detectors are drained so they never stall.
        zc.i_zc_tready = 1'b1;
        zc.q_zc_tready = 1'b1;
        slot_free      = !zc.o_tvalid || zc.o_tready;
        wd_inc         = {1'b0, wd_cnt} + 33'd1;
        cal_sh         = (log_cal_len > 32'd47) ? 6'd47 : log_cal_len[5:0];
        cal_load       = 48'd1 << cal_sh;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CLR;
            end
            S_CLR: begin
                det_clear = 1'b1;
                state_nxt = S_CAL_START;
            end
            S_CAL_START: begin
                init_cal_i = 1'b1;
                init_cal_q = 1'b1;
                state_nxt  = (log_cal_len == 32'd0) ? S_TRACK : S_CAL_WAIT;
            end
            S_CAL_WAIT: begin
                if (s_tvalid && cal_cnt == 48'd1) state_nxt = S_TRACK;
            end
            S_TRACK: begin
                tracking = 1'b1;
                if (slot_free) begin
                    if (zc.i_zc_tvalid && zc.q_zc_tvalid) begin
                        grant_i = last_grant_q;
                        grant_q = !last_grant_q;
                    end else begin
                        grant_i = zc.i_zc_tvalid;
                        grant_q = zc.q_zc_tvalid;
                    end
                end
                zc.i_zc_tready = grant_i;
                zc.q_zc_tready = grant_q;
                // An accept in the same cycle restarts the window instead.
                if (timeout != 32'd0 && s_tvalid && !(grant_i || grant_q) &&
                    wd_inc >= {1'b0, timeout}) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_CLR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (clear) state_nxt = S_IDLE;
        enter_clr = (state_nxt == S_CLR) && (state != S_CLR);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state        <= S_IDLE;
            cal_cnt      <= '0;
            wd_cnt       <= '0;
            recal_count  <= '0;
            last_grant_q <= 1'b1;
            zc.o_tvalid  <= 1'b0;
            zc.o_tdata   <= '0;
            zc.o_tuser   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_CAL_START) begin
                cal_cnt <= cal_load;
            end else if (state == S_CAL_WAIT && s_tvalid) begin
                cal_cnt <= cal_cnt - 48'd1;
            end

            if (state != S_TRACK || grant_i || grant_q || wd_fire) begin
                wd_cnt <= '0;
            end else if (s_tvalid) begin
                wd_cnt <= wd_cnt + 32'd1;
            end

            if (wd_fire && recal_count != '1) begin
                recal_count <= recal_count + 1'b1;
            end

            if (enter_clr) begin
                zc.o_tvalid <= 1'b0;
            end else if (grant_i || grant_q) begin
                zc.o_tvalid  <= 1'b1;
                zc.o_tdata   <= grant_i ? zc.i_zc_tdata : zc.q_zc_tdata;
                zc.o_tuser   <= grant_q;
                last_grant_q <= grant_q;
            end else if (zc.o_tready) begin
                zc.o_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zc_track_ctrl.sv
// Self-checking bench for zc_track_ctrl: a directed table of per-cycle
// vectors, hand-written multi-cycle sequences (calibration timing, watchdog,
// soft clear) and a randomized run against a behavioural model.
module tb_zc_track_ctrl;

    localparam int unsigned RW = 2;
    localparam logic [31:0] QM = 32'hFFFF_FF9C;

    logic          clk = 1'b0;
    logic          reset, clear, start, s_tvalid;
    logic [31:0]   log_cal_len, timeout;
    logic          det_clear, init_cal_i, init_cal_q, tracking;
    logic [RW-1:0] recal_count;

    zc_track_ctrl_if #(.COUNTER_SIZE(32)) zc ();

    zc_track_ctrl #(.COUNTER_SIZE(32), .RECAL_CNT_W(RW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start),
        .log_cal_len(log_cal_len), .timeout(timeout), .s_tvalid(s_tvalid),
        .det_clear(det_clear), .init_cal_i(init_cal_i), .init_cal_q(init_cal_q),
        .zc(zc), .tracking(tracking), .recal_count(recal_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        st, sv, iv, qv, rdy;
        logic [31:0] id, qd;
        logic        dc, ic, trk, ir, qr, ov, ou;
        logic [31:0] od;
    } vec_t;
    vec_t vt[$];

    function automatic void add(input int st, sv, iv, qv, input int unsigned id, qd,
                                input int rdy, dc, ic, trk, ir, qr, ov, ou,
                                input int unsigned od);
        vec_t v;
        v.st = (st != 0); v.sv = (sv != 0); v.iv = (iv != 0); v.qv = (qv != 0);
        v.id = id; v.qd = qd; v.rdy = (rdy != 0);
        v.dc = (dc != 0); v.ic = (ic != 0); v.trk = (trk != 0);
        v.ir = (ir != 0); v.qr = (qr != 0); v.ov = (ov != 0); v.ou = (ou != 0);
        v.od = od;
        vt.push_back(v);
    endfunction

    // Reset/clear, run the clear-calibrate sequence and measure its timing.
    task automatic cal_seq(input int lcl, input string tag);
        int dc_n, ici_n, icq_n, ic_at, trk_at, exp_gap;
        dc_n = 0; ici_n = 0; icq_n = 0; ic_at = -1; trk_at = -1;
        exp_gap = (lcl == 0) ? 1 : (1 << lcl) + 1;
        log_cal_len = lcl; s_tvalid = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; #1;
        for (int c = 0; c < 300; c++) begin
            if (det_clear) dc_n++;
            if (init_cal_i) begin ici_n++; ic_at = c; end
            if (init_cal_q) icq_n++;
            if (tracking) begin trk_at = c; break; end
            @(posedge clk); #2;
        end
        chk({tag, "_det_clear_cycles"}, 64'(dc_n), 64'd1);
        chk({tag, "_init_i_cycles"}, 64'(ici_n), 64'd1);
        chk({tag, "_init_q_cycles"}, 64'(icq_n), 64'd1);
        chk({tag, "_track_reached"}, 64'(trk_at >= 0), 64'd1);
        chk({tag, "_cal_to_track"}, 64'(trk_at - ic_at), 64'(exp_gap));
    endtask

    // Behavioural reference model for the random run.
    typedef enum int {M_IDLE, M_CLR, M_CALS, M_CALW, M_TRK} mph_t;
    mph_t              m_phase;
    longint unsigned   m_cal_left;
    int unsigned       m_wd;
    int unsigned       m_recal;
    logic              m_ov, m_ou, m_pref_q;
    logic [31:0]       m_od;

    function automatic void model_reset();
        m_phase = M_IDLE; m_cal_left = 0; m_wd = 0; m_recal = 0;
        m_ov = 1'b0; m_ou = 1'b0; m_od = '0; m_pref_q = 1'b0;
    endfunction

    initial begin
        logic [7:0] act_f, exp_f;
        int n, trk_n, busy;
        logic g_i, g_q, slot;

        reset = 1'b1; clear = 1'b0; start = 1'b0; s_tvalid = 1'b0;
        log_cal_len = 32'd2; timeout = 32'd0;
        zc.i_zc_tvalid = 1'b0; zc.q_zc_tvalid = 1'b0;
        zc.i_zc_tdata = '0; zc.q_zc_tdata = '0; zc.o_tready = 1'b0;

        // Directed per-cycle table (log_cal_len = 2, watchdog off).
        //  st sv iv qv id   qd  rdy  dc ic trk ir qr ov ou od
        add(1, 0, 0, 0, 0,   0,  0,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1,   2,  1,   1, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0,  1,   0, 1, 0,  1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0,  1,   0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 100, QM, 1,   0, 0, 1,  1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 100, QM, 1,   0, 0, 1,  0, 1, 1, 0, 100);
        add(0, 0, 1, 1, 100, QM, 1,   0, 0, 1,  1, 0, 1, 1, QM);
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 1, 100, QM, 0,   0, 0, 1,  0, 0, 1, 0, 100);
        add(0, 0, 1, 1, 100, QM, 1,   0, 0, 1,  0, 1, 1, 0, 100);
        add(0, 0, 0, 0, 0,   0,  1,   0, 0, 1,  0, 0, 1, 1, QM);
        add(0, 0, 0, 1, 0,   7,  1,   0, 0, 1,  0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 5,   0,  0,   0, 0, 1,  0, 0, 1, 1, 7);
        add(0, 0, 1, 0, 5,   0,  1,   0, 0, 1,  1, 0, 1, 1, 7);
        add(0, 0, 0, 0, 0,   0,  1,   0, 0, 1,  0, 0, 1, 0, 5);
        add(1, 0, 0, 0, 0,   0,  0,   0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0,  0,   0, 0, 1,  0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        act_f = {det_clear, init_cal_i, init_cal_q, tracking,
                 zc.i_zc_tready, zc.q_zc_tready, zc.o_tvalid, 1'b0};
        chk("reset_flags", 64'(act_f), 64'b0000_1100);
        chk("reset_recal", 64'(recal_count), 64'd0);

        for (int r = 0; r < vt.size(); r++) begin
            @(posedge clk); #1;
            start = vt[r].st; s_tvalid = vt[r].sv;
            zc.i_zc_tvalid = vt[r].iv; zc.q_zc_tvalid = vt[r].qv;
            zc.i_zc_tdata = vt[r].id; zc.q_zc_tdata = vt[r].qd;
            zc.o_tready = vt[r].rdy;
            #1;
            act_f = {det_clear, init_cal_i, init_cal_q, tracking,
                     zc.i_zc_tready, zc.q_zc_tready, zc.o_tvalid, 1'b0};
            exp_f = {vt[r].dc, vt[r].ic, vt[r].ic, vt[r].trk,
                     vt[r].ir, vt[r].qr, vt[r].ov, 1'b0};
            chk($sformatf("vec%0d_flags", r), 64'(act_f), 64'(exp_f));
            if (vt[r].ov)
                chk($sformatf("vec%0d_beat", r), {31'd0, zc.o_tuser, zc.o_tdata},
                    {31'd0, vt[r].ou, vt[r].od});
        end

        // Clear in TRACK with a beat pending.
        @(posedge clk); #1;
        start = 1'b0; s_tvalid = 1'b0;
        zc.i_zc_tvalid = 1'b1; zc.i_zc_tdata = 32'd9; zc.o_tready = 1'b0;
        @(posedge clk); #1;
        zc.i_zc_tvalid = 1'b0; clear = 1'b1;
        #1;
        chk("pre_clear_ov", 64'(zc.o_tvalid), 64'd1);
        chk("pre_clear_data", 64'(zc.o_tdata), 64'd9);
        @(posedge clk); #1;
        clear = 1'b0; zc.o_tready = 1'b1;
        #1;
        chk("clear_trk_ov", {62'd0, tracking, zc.o_tvalid}, 64'd0);
        chk("clear_treadys", {62'd0, zc.i_zc_tready, zc.q_zc_tready}, 64'd3);

        cal_seq(4, "cal16");

        // Watchdog: 50 samples without a crossing.
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0; #1;
        timeout = 32'd50;
        cal_seq(0, "cal0");
        n = 0;
        for (int c = 0; c < 120; c++) begin
            if (!tracking) break;
            n++;
            @(posedge clk); #2;
        end
        chk("wd_samples", 64'(n), 64'd50);
        chk("wd_det_clear", 64'(det_clear), 64'd1);
        chk("wd_recal1", 64'(recal_count), 64'd1);
        @(posedge clk); #2;
        chk("wd_init_cal", {62'd0, init_cal_i, init_cal_q}, 64'd3);
        @(posedge clk); #2;
        chk("wd_retrack", 64'(tracking), 64'd1);

        // Crossing at sample 49 restarts the window: 49 + 50 tracking cycles.
        trk_n = 0;
        for (int c = 1; c <= 140; c++) begin
            zc.i_zc_tvalid = (c == 49);
            if (!tracking) break;
            trk_n++;
            @(posedge clk); #2;
        end
        zc.i_zc_tvalid = 1'b0;
        chk("wd_cancel_cycles", 64'(trk_n), 64'd99);
        chk("wd_recal2", 64'(recal_count), 64'd2);

        // Clear during CAL_WAIT.
        log_cal_len = 32'd4;
        repeat (5) begin @(posedge clk); #2; end
        clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0; #1;
        chk("calw_clear_flags", {60'd0, tracking, det_clear, init_cal_i, zc.o_tvalid}, 64'd0);
        chk("calw_clear_recal", 64'(recal_count), 64'd0);
        busy = 0;
        for (int c = 0; c < 30; c++) begin
            if (tracking || det_clear || init_cal_i) busy++;
            @(posedge clk); #2;
        end
        chk("idle_hold", 64'(busy), 64'd0);
        timeout = 32'd0;
        cal_seq(4, "restart");

        // Randomized run against the model.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (cyc % 200 == 0) log_cal_len = $urandom_range(0, 3);
            if (cyc % 150 == 0) timeout = $urandom_range(0, 10);
            start = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 499) == 0);
            s_tvalid = ($urandom_range(0, 3) != 0);
            zc.i_zc_tvalid = ($urandom_range(0, 7) == 0);
            zc.q_zc_tvalid = ($urandom_range(0, 7) == 0);
            zc.i_zc_tdata = $urandom;
            zc.q_zc_tdata = $urandom;
            zc.o_tready = ($urandom_range(0, 3) != 0);
            #1;

            slot = !m_ov || zc.o_tready;
            g_i = 1'b0; g_q = 1'b0;
            if (m_phase == M_TRK && slot) begin
                if (zc.i_zc_tvalid && zc.q_zc_tvalid) begin
                    g_i = !m_pref_q; g_q = m_pref_q;
                end else begin
                    g_i = zc.i_zc_tvalid; g_q = zc.q_zc_tvalid;
                end
            end
            act_f = {det_clear, init_cal_i, init_cal_q, tracking,
                     zc.i_zc_tready, zc.q_zc_tready, zc.o_tvalid, 1'b0};
            exp_f = {m_phase == M_CLR, m_phase == M_CALS, m_phase == M_CALS,
                     m_phase == M_TRK, (m_phase == M_TRK) ? g_i : 1'b1,
                     (m_phase == M_TRK) ? g_q : 1'b1, m_ov, 1'b0};
            chk($sformatf("rnd%0d_flags", cyc), 64'(act_f), 64'(exp_f));
            chk($sformatf("rnd%0d_recal", cyc), 64'(recal_count), 64'(m_recal));
            if (m_ov)
                chk($sformatf("rnd%0d_beat", cyc), {31'd0, zc.o_tuser, zc.o_tdata},
                    {31'd0, m_ou, m_od});

            if (clear) begin
                model_reset();
            end else begin
                case (m_phase)
                    M_IDLE: if (start) m_phase = M_CLR;
                    M_CLR:  m_phase = M_CALS;
                    M_CALS: begin
                        if (log_cal_len == 0) begin
                            m_phase = M_TRK; m_wd = 0;
                        end else begin
                            m_cal_left = 64'd1 << ((log_cal_len > 47) ? 47 : log_cal_len);
                            m_phase = M_CALW;
                        end
                    end
                    M_CALW: begin
                        if (s_tvalid) begin
                            m_cal_left--;
                            if (m_cal_left == 0) begin m_phase = M_TRK; m_wd = 0; end
                        end
                    end
                    M_TRK: begin
                        if (g_i || g_q) begin
                            m_ov = 1'b1; m_ou = g_q;
                            m_od = g_i ? zc.i_zc_tdata : zc.q_zc_tdata;
                            m_pref_q = g_i; m_wd = 0;
                        end else begin
                            if (zc.o_tready) m_ov = 1'b0;
                            if (s_tvalid) begin
                                m_wd++;
                                if (timeout != 0 && m_wd >= timeout) begin
                                    m_phase = M_CLR; m_ov = 1'b0; m_wd = 0;
                                    if (m_recal < (1 << RW) - 1) m_recal++;
                                end
                            end
                        end
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
